// File: rtl/video_pkg.sv
// Shared raster types and constants: 640x480@60 default timing, counter width, RGB struct and bar colours.
package video_pkg;

    localparam int unsigned CntW   = 10;
    localparam int unsigned CntMax = 1 << CntW;

    localparam int unsigned DefColActive = 640;
    localparam int unsigned DefColFront  = 16;
    localparam int unsigned DefColSync   = 96;
    localparam int unsigned DefColBack   = 48;
    localparam int unsigned DefRowActive = 480;
    localparam int unsigned DefRowFront  = 10;
    localparam int unsigned DefRowSync   = 2;
    localparam int unsigned DefRowBack   = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam rgb_t BarRgb [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/test_pattern_gen.sv
// Registered RGB test pattern (colour bars or 32x32 checker) for the pixel at col_i/row_i.
// One cycle latency, matching the sync decode registers in the top; no backpressure.
module test_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned NumColActive = DefColActive
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [CntW-1:0] col_i,
    input  logic [CntW-1:0] row_i,
    input  logic            de_i,
    input  logic            line_end_i,
    input  logic            pat_sel_i,
    output logic [23:0]     rgb_o
);

    localparam logic [CntW-1:0] BarLast = CntW'(NumColActive / 8 - 1);

    logic [CntW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    rgb_t            rgb_q, rgb_d;

    // Bar state always describes col_i; bar 7 absorbs any remainder columns.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (line_end_i) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_cnt_q == BarLast) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        rgb_d = '0;
        if (de_i) begin
            if (pat_sel_i) begin
                rgb_d = (col_i[5] ^ row_i[5]) ? 24'hFFFFFF : 24'h000000;
            end else begin
                rgb_d = BarRgb[bar_idx_q];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/video_timing_sync.sv
// Raster timing generator: DE, H/V sync, coordinates, frame start and RGB test pattern.
// All outputs registered one cycle after the col/row counters; free-running, no backpressure.
module video_timing_sync
    import video_pkg::*;
#(
    parameter int unsigned NumColActive    = DefColActive,
    parameter int unsigned NumColFront     = DefColFront,
    parameter int unsigned NumColSync      = DefColSync,
    parameter int unsigned NumColBack      = DefColBack,
    parameter int unsigned NumRowActive    = DefRowActive,
    parameter int unsigned NumRowFront     = DefRowFront,
    parameter int unsigned NumRowSync      = DefRowSync,
    parameter int unsigned NumRowBack      = DefRowBack,
    parameter logic        HSyncActiveHigh = 1'b0,
    parameter logic        VSyncActiveHigh = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pat_sel_i,
    output logic            de_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic [CntW-1:0] col_o,
    output logic [CntW-1:0] row_o,
    output logic            frame_start_o,
    output logic [23:0]     rgb_o
);

    localparam int unsigned ColTotal = NumColActive + NumColFront + NumColSync + NumColBack;
    localparam int unsigned RowTotal = NumRowActive + NumRowFront + NumRowSync + NumRowBack;
    localparam int unsigned HsStart  = NumColActive + NumColFront;
    localparam int unsigned HsEnd    = HsStart + NumColSync;
    localparam int unsigned VsStart  = NumRowActive + NumRowFront;
    localparam int unsigned VsEnd    = VsStart + NumRowSync;
    localparam logic [CntW-1:0] ColLast = CntW'(ColTotal - 1);
    localparam logic [CntW-1:0] RowLast = CntW'(RowTotal - 1);

    if (ColTotal > CntMax || RowTotal > CntMax || NumColActive < 8) begin : g_size_check
        $error("video_timing_sync: raster totals exceed counter range or active width below 8");
    end

    logic [CntW-1:0] col_q, col_d, row_q, row_d;
    logic [CntW-1:0] col_out_q, row_out_q;
    logic            de_q, hsync_q, vsync_q, fs_q;
    logic            line_end, frame_end;
    logic            de_d, hs_on, vs_on;

    assign line_end  = (col_q == ColLast);
    assign frame_end = (row_q == RowLast);

    always_comb begin
        col_d = col_q + CntW'(1);
        row_d = row_q;
        if (line_end) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + CntW'(1);
        end
    end

    assign de_d  = (32'(col_q) < NumColActive) && (32'(row_q) < NumRowActive);
    assign hs_on = (32'(col_q) >= HsStart) && (32'(col_q) < HsEnd);
    assign vs_on = (32'(row_q) >= VsStart) && (32'(row_q) < VsEnd);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q     <= '0;
            row_q     <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
            de_q      <= 1'b0;
            hsync_q   <= ~HSyncActiveHigh;
            vsync_q   <= ~VSyncActiveHigh;
            fs_q      <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            col_out_q <= col_q;
            row_out_q <= row_q;
            de_q      <= de_d;
            hsync_q   <= hs_on ? HSyncActiveHigh : ~HSyncActiveHigh;
            vsync_q   <= vs_on ? VSyncActiveHigh : ~VSyncActiveHigh;
            fs_q      <= (col_q == '0) && (row_q == '0);
        end
    end

    test_pattern_gen #(
        .NumColActive(NumColActive)
    ) u_pattern (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .col_i     (col_q),
        .row_i     (row_q),
        .de_i      (de_d),
        .line_end_i(line_end),
        .pat_sel_i (pat_sel_i),
        .rgb_o     (rgb_o)
    );

    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign col_o         = col_out_q;
    assign row_o         = row_out_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_timing_sync.sv
// Bench for video_timing_sync: a default 640x480 instance plus a small active-high-sync instance for frame-level checks.
module tb_video_timing_sync;

    logic clk = 1'b0;
    logic rst_b_n = 1'b1, rst_s_n = 1'b1;
    logic pat_b = 1'b0, pat_s = 1'b0;

    logic de_b, hs_b, vs_b, fs_b, de_s, hs_s, vs_s, fs_s;
    logic [9:0] col_b, row_b, col_s, row_s;
    logic [23:0] rgb_b, rgb_s;

    int total = 0;
    int bad = 0;
    int pix_b = 0;
    int pix_s = 0;

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    always #5 clk = ~clk;

    video_timing_sync u_big (
        .clk_i(clk), .rst_ni(rst_b_n), .pat_sel_i(pat_b),
        .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b),
        .col_o(col_b), .row_o(row_b), .frame_start_o(fs_b), .rgb_o(rgb_b)
    );

    video_timing_sync #(
        .NumColActive(60), .NumColFront(4), .NumColSync(6), .NumColBack(10),
        .NumRowActive(24), .NumRowFront(3), .NumRowSync(2), .NumRowBack(5),
        .HSyncActiveHigh(1'b1), .VSyncActiveHigh(1'b1)
    ) u_small (
        .clk_i(clk), .rst_ni(rst_s_n), .pat_sel_i(pat_s),
        .de_o(de_s), .hsync_o(hs_s), .vsync_o(vs_s),
        .col_o(col_s), .row_o(row_s), .frame_start_o(fs_s), .rgb_o(rgb_s)
    );

    // Expected {de, hsync, vsync, frame_start, col, row, rgb} for the pix-th pixel after reset release.
    function automatic logic [47:0] model(input int pix, input bit pat,
                                          input int ca, input int cf, input int cs, input int cb,
                                          input int ra, input int rf, input int rs, input int rb,
                                          input bit hp, input bit vp);
        int ct, rt, c, r, bi;
        bit de, hs, vs;
        logic [23:0] rgb;
        ct = ca + cf + cs + cb;
        rt = ra + rf + rs + rb;
        c = pix % ct;
        r = (pix / ct) % rt;
        de = (c < ca) && (r < ra);
        hs = (c >= ca + cf) && (c < ca + cf + cs);
        vs = (r >= ra + rf) && (r < ra + rf + rs);
        rgb = 24'h0;
        if (de && pat) begin
            rgb = ((((c / 32) + (r / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        end else if (de) begin
            bi = c / (ca / 8);
            if (bi > 7) bi = 7;
            rgb = BARS[bi];
        end
        return {de, hs ? hp : ~hp, vs ? vp : ~vp, (c == 0) && (r == 0), 10'(c), 10'(r), rgb};
    endfunction

    function automatic logic [47:0] model_b(input int pix, input bit pat);
        return model(pix, pat, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic logic [47:0] model_s(input int pix, input bit pat);
        return model(pix, pat, 60, 4, 6, 10, 24, 3, 2, 5, 1'b1, 1'b1);
    endfunction

    task automatic tick_b(input bit p);
        pat_b = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_s(input bit p);
        pat_s = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        pat_b = 1'b0;
        #1 rst_b_n = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({de_b, hs_b, vs_b, fs_b} !== 4'b0110) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0110", {de_b, hs_b, vs_b, fs_b});
        end
        total++;
        if (rgb_b !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", rgb_b); end
        total++;
        if ({col_b, row_b} !== 20'h0) begin bad++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", col_b, row_b); end
        rst_b_n = 1'b1;
        tick_b(1'b0);
        total++;
        if (de_b !== 1'b1) begin bad++; $display("FAIL first_de got=%b exp=1", de_b); end
        total++;
        if (fs_b !== 1'b1) begin bad++; $display("FAIL first_fs got=%b exp=1", fs_b); end
        total++;
        if (rgb_b !== 24'hFFFFFF) begin bad++; $display("FAIL first_rgb got=%h exp=FFFFFF", rgb_b); end
        pix_b = 1;
    endtask

    task automatic test_colour_bars();
        int cols [7] = '{79, 80, 559, 560, 639, 640, 0};
        logic [23:0] rgbs [7] = '{24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF};
        bit des [7] = '{1, 1, 1, 1, 1, 0, 1};
        logic [47:0] exp;
        for (int i = 0; i < 800; i++) begin
            tick_b(1'b0);
            exp = model_b(pix_b, 1'b0);
            total++;
            if ({de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b} !== exp) begin
                bad++; $display("FAIL bars_vec pix=%0d got=%h exp=%h", pix_b, {de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b}, exp);
            end
            for (int k = 0; k < 7; k++) begin
                if ((pix_b % 800) == cols[k]) begin
                    total++;
                    if (rgb_b !== rgbs[k] || de_b !== des[k]) begin
                        bad++; $display("FAIL bar_col%0d got=%h/%b exp=%h/%b", cols[k], rgb_b, de_b, rgbs[k], des[k]);
                    end
                end
            end
            pix_b++;
        end
    endtask

    task automatic test_line_timing();
        logic [47:0] exp;
        bit p;
        int de_cnt = 0;
        int hs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            p = 1'($urandom_range(0, 1));
            tick_b(p);
            exp = model_b(pix_b, p);
            total++;
            if ({de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b} !== exp) begin
                bad++; $display("FAIL line_vec pix=%0d got=%h exp=%h", pix_b, {de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b}, exp);
            end
            de_cnt += int'(de_b);
            if (hs_b === 1'b0) begin
                hs_cnt++;
                total++;
                if (col_b < 10'd656 || col_b > 10'd751) begin
                    bad++; $display("FAIL hsync_col got=%0d exp=656..751", col_b);
                end
            end
            pix_b++;
        end
        total++;
        if (de_cnt != 640) begin bad++; $display("FAIL de_per_line got=%0d exp=640", de_cnt); end
        total++;
        if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
    endtask

    task automatic test_checker();
        int cc [5] = '{31, 32, 32, 100, 101};
        int rr [5] = '{0, 0, 32, 1, 1};
        logic [23:0] rgbs [5] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFF00, 24'hFFFFFF};
        logic [47:0] exp;
        int c, r;
        bit p;
        rst_b_n = 1'b0;
        @(negedge clk);
        rst_b_n = 1'b1;
        pix_b = 0;
        for (int i = 0; i < 32 * 800 + 33; i++) begin
            c = pix_b % 800;
            r = pix_b / 800;
            p = !(r == 1 && c <= 100);
            tick_b(p);
            exp = model_b(pix_b, p);
            total++;
            if ({de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b} !== exp) begin
                bad++; $display("FAIL checker_vec pix=%0d got=%h exp=%h", pix_b, {de_b, hs_b, vs_b, fs_b, col_b, row_b, rgb_b}, exp);
            end
            for (int k = 0; k < 5; k++) begin
                if (c == cc[k] && r == rr[k]) begin
                    total++;
                    if (rgb_b !== rgbs[k]) begin
                        bad++; $display("FAIL checker_%0d_%0d got=%h exp=%h", c, r, rgb_b, rgbs[k]);
                    end
                end
            end
            pix_b++;
        end
    endtask

    task automatic test_frame_timing();
        logic [47:0] exp;
        bit p;
        logic vs_prev = 1'b0;
        int de_cnt = 0;
        int vs_cnt = 0;
        int fs_cnt = 0;
        int fs_first = -1;
        int fs_last = -1;
        #1 rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s} !== 48'h0) begin
            bad++; $display("FAIL small_reset got=%h exp=0", {de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s});
        end
        rst_s_n = 1'b1;
        pix_s = 0;
        for (int i = 0; i < 2 * 2720 + 1; i++) begin
            p = 1'($urandom_range(0, 1));
            tick_s(p);
            exp = model_s(pix_s, p);
            total++;
            if ({de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s} !== exp) begin
                bad++; $display("FAIL frame_vec pix=%0d got=%h exp=%h", pix_s, {de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s}, exp);
            end
            if (pix_s < 2720) begin
                de_cnt += int'(de_s);
                vs_cnt += int'(vs_s);
            end
            if (vs_s === 1'b1 && vs_prev === 1'b0) begin
                total++;
                if (col_s !== 10'd0) begin bad++; $display("FAIL vsync_edge_col got=%0d exp=0", col_s); end
            end
            vs_prev = vs_s;
            if (fs_s === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = pix_s;
                fs_last = pix_s;
            end
            pix_s++;
        end
        total++;
        if (de_cnt != 1440) begin bad++; $display("FAIL de_per_frame got=%0d exp=1440", de_cnt); end
        total++;
        if (vs_cnt != 160) begin bad++; $display("FAIL vsync_cycles got=%0d exp=160", vs_cnt); end
        total++;
        if (fs_cnt != 3 || fs_last - fs_first != 5440) begin
            bad++; $display("FAIL frame_period got=%0d pulses span %0d exp=3 span 5440", fs_cnt, fs_last - fs_first);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [47:0] exp;
        bit p;
        int max_row = 0;
        int fs_cnt = 0;
        // Stop on row 27 col 30 of the third frame, inside the vsync pulse.
        while (pix_s <= 2 * 2720 + 27 * 80 + 30) begin
            p = 1'($urandom_range(0, 1));
            tick_s(p);
            exp = model_s(pix_s, p);
            total++;
            if ({de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s} !== exp) begin
                bad++; $display("FAIL prereset_vec pix=%0d got=%h exp=%h", pix_s, {de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s}, exp);
            end
            pix_s++;
        end
        total++;
        if (vs_s !== 1'b1 || col_s !== 10'd30 || row_s !== 10'd27) begin
            bad++; $display("FAIL prereset_pos got=%b,%0d,%0d exp=1,30,27", vs_s, col_s, row_s);
        end
        #2 rst_s_n = 1'b0;
        #1;
        total++;
        if ({de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s} !== 48'h0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", {de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s});
        end
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
        pix_s = 0;
        for (int i = 0; i < 2721; i++) begin
            p = 1'($urandom_range(0, 1));
            tick_s(p);
            exp = model_s(pix_s, p);
            total++;
            if ({de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s} !== exp) begin
                bad++; $display("FAIL restart_vec pix=%0d got=%h exp=%h", pix_s, {de_s, hs_s, vs_s, fs_s, col_s, row_s, rgb_s}, exp);
            end
            if (int'(row_s) > max_row) max_row = int'(row_s);
            fs_cnt += int'(fs_s);
            pix_s++;
        end
        total++;
        if (max_row != 33 || fs_cnt != 2) begin
            bad++; $display("FAIL restart_frame got=maxrow %0d pulses %0d exp=33 2", max_row, fs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_colour_bars();
        test_line_timing();
        test_checker();
        test_frame_timing();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
